uart_hex_formatter: RTL and testbench
=====================================

UART_HEX_FORMATTER -- requirements
Module: uart_hex_formatter

Interface
REQ-001 Parameter DELAY_FRAMES, default 234, SHALL be the clock cycles per UART bit time of the downstream transmitter (27 MHz / 115200).
REQ-002 Parameter HOLDOFF_CYCLES, default 262150, SHALL be the cycles uart_enable stays low after a message, covering the transmitter's post-message guard (262144 cycles) plus margin.
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port capture, input, 1 bit: single-cycle request to format and send value.
REQ-006 Port value, input, 32 bits: word to print; sampled on the cycle capture is accepted.
REQ-007 Port addr, input, 4 bits: byte index driven by the downstream transmitter.
REQ-008 Port data, output, 8 bits: ASCII byte at buffer[addr].
REQ-009 Port uart_enable, output, 1 bit: start/hold request to the transmitter.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port overrun, output, 1 bit: one-cycle pulse when capture arrives while busy.

Function
REQ-012 The block SHALL hold a 12-byte buffer laid out as "0x", eight hex digits MSB-nibble first, 0x0D, 0x0A.
REQ-013 The FSM SHALL have states IDLE, CONVERT, SEND, DRAIN, HOLDOFF.
REQ-014 In IDLE, capture=1 SHALL latch value, write buffer[0]=0x30 and buffer[1]=0x78, clear the nibble index to 0, and enter CONVERT next cycle.
REQ-015 CONVERT SHALL write exactly one digit per cycle, nibble k (bits 31-4k..28-4k) to buffer[2+k], for k=0..7; after k=7 it SHALL write buffer[10]=0x0D and buffer[11]=0x0A and enter SEND (8 cycles in CONVERT).
REQ-016 Digit encoding: nibble 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 (uppercase) unless REQ-030 applies.
REQ-017 uart_enable SHALL be registered, rising on the first SEND cycle and held high through SEND and DRAIN.
REQ-018 data SHALL be registered: data equals buffer[addr] one cycle after addr changes; addr values 12-15 SHALL yield 0x00.
REQ-019 SEND SHALL move to DRAIN on the first cycle addr==11 is observed.
REQ-020 DRAIN SHALL count 11*DELAY_FRAMES cycles (last frame plus one bit margin), then drive uart_enable low and enter HOLDOFF.
REQ-021 HOLDOFF SHALL keep uart_enable low for HOLDOFF_CYCLES cycles, then enter IDLE.
REQ-022 The shared cycle counter SHALL be 24 bits, clear on every state entry, and never wrap within a state.
REQ-023 Capture in any state but IDLE SHALL be ignored (buffer and value unchanged) and SHALL pulse overrun for one cycle.
REQ-024 Capture on the same cycle HOLDOFF ends SHALL be ignored and flagged as overrun; it is accepted only from IDLE.
REQ-025 The buffer SHALL not change from SEND entry until the next accepted capture.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, uart_enable=0, busy=0, overrun=0, data=0x00, counter=0, all buffer bytes=0x00.
REQ-027 Reset asserted mid-SEND or mid-DRAIN SHALL drop uart_enable within the reset assertion, without completing the message.
REQ-028 After rst_n rises, the first capture SHALL be accepted no earlier than the following rising edge.
REQ-029 No output SHALL glitch high during reset release.

Configuration
REQ-030 With macro UART_HEX_LOWERCASE_EN defined, nibbles 10-15 SHALL encode as 0x61-0x66; undefined, they SHALL encode as 0x41-0x46; all other behaviour and timing identical.

Verification
REQ-031 capture with value=0x1234ABCD, addr stepped 0..11 -> data sequence 30 78 31 32 33 34 41 42 43 44 0D 0A; uart_enable rises 10 cycles after capture.
REQ-032 UART_HEX_LOWERCASE_EN defined, value=0xDEADBEEF -> bytes 2-9 read 64 65 61 64 62 65 65 66.
REQ-033 addr held at 11 from SEND entry -> uart_enable falls exactly 11*234=2574 cycles after DRAIN entry; busy falls 262150 cycles later.
REQ-034 second capture (value=0xFFFFFFFF) during DRAIN -> overrun one-cycle pulse, buffer still holds the first message.
REQ-035 rst_n pulsed low mid-SEND -> uart_enable=0, busy=0, data=0x00 asynchronously; a fresh capture after release produces a correct message.
REQ-036 addr=13 during SEND -> data=0x00 one cycle later.

Source files
------------

// File: rtl/uart_hex_formatter.sv
// Formats a captured 32-bit word as "0xHHHHHHHH\r\n" for a byte-addressed UART transmitter.
// Define UART_HEX_LOWERCASE_EN to emit lowercase hex letters instead of uppercase.
module uart_hex_formatter #(
    parameter int DELAY_FRAMES   = 234,
    parameter int HOLDOFF_CYCLES = 262150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic [31:0] value,
    input  logic [3:0]  addr,
    output logic [7:0]  data,
    output logic        uart_enable,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SEND    = 3'd2,
        DRAIN   = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    // Last counter value in DRAIN covers the final frame plus one bit of margin.
    localparam logic [23:0] DRAIN_LAST = 24'(11 * DELAY_FRAMES - 1);
    localparam logic [23:0] HOLD_LAST  = 24'(HOLDOFF_CYCLES - 1);

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [23:0] cnt_inc_s;
    logic [2:0]  nib_q;
    logic [31:0] value_q;
    logic [7:0]  hbuf_q [16];
    logic [4:0]  lsb_s;
    logic [3:0]  nibble_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = 8'h30 + {4'h0, n};
        end else begin
`ifdef UART_HEX_LOWERCASE_EN
            r = 8'h57 + {4'h0, n};
`else
            r = 8'h37 + {4'h0, n};
`endif
        end
        return r;
    endfunction

    // Nibble selection and saturating counter increment.
    always_comb begin
        lsb_s     = {3'd7 - nib_q, 2'b00};
        nibble_s  = value_q[lsb_s +: 4];
        cnt_inc_s = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
    end

    // Main FSM with registered outputs and the message buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 24'd0;
            nib_q       <= 3'd0;
            value_q     <= 32'd0;
            data        <= 8'h00;
            uart_enable <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                hbuf_q[i] <= 8'h00;
            end
        end else begin
            overrun <= capture && (state_q != IDLE);
            data    <= (addr < 4'd12) ? hbuf_q[addr] : 8'h00;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        value_q   <= value;
                        hbuf_q[0] <= 8'h30;
                        hbuf_q[1] <= 8'h78;
                        nib_q     <= 3'd0;
                        cnt_q     <= 24'd0;
                        busy      <= 1'b1;
                        state_q   <= CONVERT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CONVERT: begin
                    hbuf_q[4'd2 + {1'b0, nib_q}] <= hex_ascii(nibble_s);
                    nib_q <= nib_q + 3'd1;
                    if (nib_q == 3'd7) begin
                        hbuf_q[10] <= 8'h0D;
                        hbuf_q[11] <= 8'h0A;
                        cnt_q      <= 24'd0;
                        state_q    <= SEND;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                SEND: begin
                    uart_enable <= 1'b1;
                    if (addr == 4'd11) begin
                        cnt_q   <= 24'd0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        uart_enable <= 1'b0;
                        cnt_q       <= 24'd0;
                        state_q     <= HOLDOFF;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        busy    <= 1'b0;
                        cnt_q   <= 24'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                default: begin
                    uart_enable <= 1'b0;
                    busy        <= 1'b0;
                    cnt_q       <= 24'd0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Directed plus randomized bench for uart_hex_formatter with shortened timing parameters.
module tb_uart_hex_formatter;

    localparam int DF   = 4;
    localparam int HOLD = 20;
    localparam int DRAIN_CYC = 11 * DF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        capture;
    logic [31:0] value;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        uart_enable;
    logic        busy;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;

    uart_hex_formatter #(.DELAY_FRAMES(DF), .HOLDOFF_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .capture(capture), .value(value), .addr(addr),
        .data(data), .uart_enable(uart_enable), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference: the byte the transmitter should read at index idx for word v.
    function automatic logic [7:0] exp_byte(input logic [31:0] v, input int idx);
        int d;
        if (idx == 0) return 8'h30;
        if (idx == 1) return 8'h78;
        if (idx == 10) return 8'h0D;
        if (idx == 11) return 8'h0A;
        if (idx > 11) return 8'h00;
        d = int'((v >> (4 * (9 - idx))) & 32'hF);
        if (d < 10) return 8'(48 + d);
`ifdef UART_HEX_LOWERCASE_EN
        return 8'(87 + d);
`else
        return 8'(55 + d);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the chosen signal (0: uart_enable, 1: busy) equals lvl, or bound expires.
    task automatic wait_sig(input int which, input logic lvl, input int bound, inout int n);
        logic s;
        do begin
            step();
            n++;
            s = (which == 0) ? uart_enable : busy;
        end while (s !== lvl && n < bound);
    endtask

    task automatic read_all(input logic [31:0] v, input string tag);
        for (int i = 0; i < 12; i++) begin
            addr = 4'(i);
            step();
            check($sformatf("%s_b%0d", tag, i), {24'd0, data}, {24'd0, exp_byte(v, i)});
        end
    endtask

    task automatic run_msg(input logic [31:0] v);
        int n;
        addr = 4'd0;
        capture = 1'b1;
        value = v;
        step();
        capture = 1'b0;
        value = $urandom;
        n = 1;
        wait_sig(0, 1'b1, 50, n);
        check("latency", n, 10);
        addr = 4'd13;
        step();
        check("addr13", {24'd0, data}, 32'd0);
        read_all(v, "msg");
        n = 0;
        wait_sig(0, 1'b0, 200, n);
        check("drain", n, DRAIN_CYC);
        n = 0;
        wait_sig(1, 1'b0, 100, n);
        check("holdoff", n, HOLD);
        addr = 4'd0;
    endtask

    initial begin
        int n;
        logic [31:0] v1;
        rst_n = 1'b0;
        capture = 1'b0;
        value = 32'd0;
        addr = 4'd0;
        step();
        step();
        check("rst_en", {31'd0, uart_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
        step();

        // First message with overrun during DRAIN and capture on the final HOLDOFF cycle.
        v1 = 32'h1234ABCD;
        capture = 1'b1;
        value = v1;
        step();
        capture = 1'b0;
        n = 1;
        wait_sig(0, 1'b1, 50, n);
        check("lat1", n, 10);
        check("busy1", {31'd0, busy}, 32'd1);
        read_all(v1, "m1");
        capture = 1'b1;
        value = 32'hFFFFFFFF;
        step();
        check("ovr_pulse", {31'd0, overrun}, 32'd1);
        capture = 1'b0;
        step();
        check("ovr_clear", {31'd0, overrun}, 32'd0);
        n = 2;
        wait_sig(0, 1'b0, 200, n);
        check("drain1", n, DRAIN_CYC);
        read_all(v1, "m1keep");
        n = 12;
        while (n < HOLD - 1) begin
            step();
            n++;
        end
        check("busy_hold", {31'd0, busy}, 32'd1);
        capture = 1'b1;
        value = 32'h0;
        step();
        check("hold_end_busy", {31'd0, busy}, 32'd0);
        check("hold_end_ovr", {31'd0, overrun}, 32'd1);
        capture = 1'b0;
        addr = 4'd2;
        step();
        check("hold_end_ign", {31'd0, busy}, 32'd0);
        check("hold_end_buf", {24'd0, data}, {24'd0, exp_byte(v1, 2)});

        run_msg(32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            run_msg($urandom);
        end

        // Reset in the middle of SEND.
        capture = 1'b1;
        value = $urandom;
        step();
        capture = 1'b0;
        n = 1;
        wait_sig(0, 1'b1, 50, n);
        addr = 4'd5;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", {31'd0, uart_enable}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", {24'd0, data}, 32'd0);
        step();
        rst_n = 1'b1;
        addr = 4'd0;
        step();
        check("post_rst_data", {24'd0, data}, 32'd0);
        run_msg($urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
